kalman_gain_div: RTL and testbench
==================================

// Module: kalman_gain_div
// PURPOSE
//  Kalman gain generator: K0 = P00/(P00+R), K1 = P10/(P00+R), as unsigned Q0.13 fractions.
//  Producer of K0_out/K1_out for the P-matrix update ALU.
//  Sits between the covariance predict stage and the P update stage.
//  One shared restoring divider, used sequentially: K0 first, then K1.
// PARAMETERS
//  P_W     23  width of the P matrix entries and of the R noise term (unsigned)
//  FRAC_W  13  gain width; gain = K/2^FRAC_W; K_MAX = 2^FRAC_W-1
// PORTS
//  clk       in   1        system clock, rising edge
//  n_rst     in   1        asynchronous active-low reset
//  start     in   1        request; sampled only in IDLE
//  P00_in    in   P_W      predicted P00
//  P10_in    in   P_W      predicted P10
//  R_in      in   P_W      measurement noise variance
//  busy      out  1        high in every state except IDLE
//  done      out  1        one-cycle pulse; K0_out/K1_out/div_zero valid from this cycle on
//  K0_out    out  FRAC_W   gain for row 0
//  K1_out    out  FRAC_W   gain for row 1
//  div_zero  out  1        high when P00+R == 0 in the last completed operation
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset n_rst is asynchronous, active-low.
//  - Reset values: state=IDLE; busy=0, done=0, K0_out=0, K1_out=0, div_zero=0.
//  - Reset mid-operation aborts immediately. No partial result is ever presented.
//  - FSM: IDLE -> LOAD -> DIV0 -> DIV1 -> DONE -> IDLE.
//    - IDLE, start=1 (edge E0): latch P00, P10, R; go to LOAD. start is ignored in all other states.
//    - LOAD (edge E1):
//      - S = P00+R, P_W+1 bits, no overflow.
//      - Precompute sat0 = (P00>=S), sat1 = (P10>=S), dz = (S==0).
//      - Init the divider for K0; go to DIV0.
//    - DIV0: FRAC_W iterations, one quotient bit per cycle, dividend P00<<FRAC_W.
//      - On the last iteration, latch K0 internally; go to DIV1.
//    - DIV1: same for P10. On the last iteration, latch K1; go to DONE.
//    - DONE: outputs K0_out/K1_out/div_zero updated on entry; done=1 for this cycle only; go to IDLE.
//  - Fixed latency: done is high in the cycle after edge E0+1+2*FRAC_W (E27 by default).
//    - Saturated and zero cases run the full latency.
//  - Arithmetic: unsigned. Quotient = floor(P*2^FRAC_W / S).
//    - Divider remainder register is P_W+2 bits.
//    - sat0/sat1 force the result to K_MAX (quotient >= 2^FRAC_W cannot be represented).
//    - dz forces K0=K1=0 and div_zero=1; dz overrides sat.
//  - Outputs hold their values until the next DONE. They are not cleared at start.
//  - Back-to-back: start in the cycle after done (IDLE again) is accepted.
//  - start coinciding with the DONE cycle is ignored.
// CONFIGURATION
//  - KALMAN_GAIN_ROUND_EN defined:
//    - Each division computes one extra (guard) quotient bit, FRAC_W+1 iterations.
//    - Result = truncated + guard, saturating at K_MAX.
//    - Latency becomes 1+2*(FRAC_W+1): done after E29 by default.
//  - KALMAN_GAIN_ROUND_EN undefined: truncation, latency as above.
// STRUCTURE
//  - kalman_pkg holds:
//    - P_W/FRAC_W defaults and K_MAX;
//    - typedef enum gain_state_t {IDLE, LOAD, DIV0, DIV1, DONE};
//    - typedefs p_t (P_W bits) and k_t (FRAC_W bits).
//  - Sub-module kalman_seq_div: restoring divider with load/step/quotient/last ports.
//    - One instance, reused for K0 then K1.
//    - Iteration count comes from the parameter plus the macro.
//  - Top level: FSM, input latches, saturation/zero logic, output registers.
// TESTING
//  1. P00=1000, R=1000, P10=500, start
//     -> K0=4096, K1=2048, div_zero=0; done exactly 27 cycles after the start edge; busy high in between.
//  2. P00=5000, R=0, P10=10000 -> K0=8191, K1=8191 (both saturated); latency still 27.
//  3. P00=0, R=0, P10=77 -> K0=0, K1=0, div_zero=1; a following P00=R=1000 run -> div_zero=0.
//  4. start held high through a whole run -> only one done per run.
//     A second start pulsed mid-run is ignored; a start the cycle after done launches a new run.
//  5. n_rst low at cycle 10 of a run -> busy/done/K0/K1/div_zero=0 immediately.
//     Release, then start P00=1000, R=1000 -> K0=4096.
//  6. P00=1, R=2, P10=1 (S=3): 8192/3=2730.67 -> K0=K1=2730 without KALMAN_GAIN_ROUND_EN.
//     With the macro: K0=K1=2731, done at 29 cycles.

Source files
------------

// File: rtl/kalman_pkg.sv
`default_nettype none
// ============================================================================
// Module : kalman_pkg
// Brief  : Shared widths, state type and rounding switch (KALMAN_GAIN_ROUND_EN)
//          for the Kalman gain divider.
// Rev    : 1.0  initial release
// ============================================================================
package kalman_pkg;

    localparam int c_P_W_DEF    = 23;
    localparam int c_FRAC_W_DEF = 13;
    localparam logic [c_FRAC_W_DEF-1:0] c_K_MAX = '1;

`ifdef KALMAN_GAIN_ROUND_EN
    localparam int c_ROUND_EN = 1;
`else
    localparam int c_ROUND_EN = 0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, DIV0, DIV1, DONE} gain_state_t;

    typedef logic [c_P_W_DEF-1:0]    p_t;
    typedef logic [c_FRAC_W_DEF-1:0] k_t;

endpackage
`default_nettype wire

// File: rtl/kalman_seq_div.sv
`default_nettype none
// ============================================================================
// Module : kalman_seq_div
// Brief  : Restoring divider, one quotient bit per step; one extra guard
//          iteration when KALMAN_GAIN_ROUND_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module kalman_seq_div
    import kalman_pkg::*;
#(
    parameter int P_W   = c_P_W_DEF,
    parameter int ITERS = c_FRAC_W_DEF + c_ROUND_EN
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             step,
    input  logic [P_W-1:0]   dividend,
    input  logic [P_W:0]     divisor,
    output logic [ITERS-1:0] quotient,
    output logic             last
);

    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITERS - 1);

    logic [P_W+1:0]   r_rem;
    logic [P_W:0]     r_div;
    logic [ITERS-2:0] r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [P_W+1:0]   w_shift;
    logic             w_ge;
    logic [P_W+1:0]   w_rem_next;

    // Remainder stays below the divisor whenever the result is not saturated,
    // so the shifted value always fits in P_W+2 bits.
    assign w_shift    = r_rem << 1;
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_rem_next = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    assign quotient   = {r_q, w_ge};
    assign last       = step && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_rem <= {2'b00, dividend};
            r_div <= divisor;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (step) begin
            r_rem <= w_rem_next;
            r_q   <= quotient[ITERS-2:0];
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kalman_gain_div.sv
`default_nettype none
// ============================================================================
// Module : kalman_gain_div
// Brief  : K0 = P00/(P00+R), K1 = P10/(P00+R) as Q0.FRAC_W gains using one
//          shared sequential divider; KALMAN_GAIN_ROUND_EN selects rounding.
// Rev    : 1.0  initial release
// ============================================================================
module kalman_gain_div
    import kalman_pkg::*;
#(
    parameter int P_W    = c_P_W_DEF,
    parameter int FRAC_W = c_FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [P_W-1:0]    P00_in,
    input  logic [P_W-1:0]    P10_in,
    input  logic [P_W-1:0]    R_in,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W-1:0] K0_out,
    output logic [FRAC_W-1:0] K1_out,
    output logic              div_zero
);

    localparam int c_Q_W = FRAC_W + c_ROUND_EN;
    localparam logic [FRAC_W-1:0] c_KMAX = '1;

    gain_state_t       r_state;
    gain_state_t       w_state_next;

    logic [P_W-1:0]    r_p00;
    logic [P_W-1:0]    r_p10;
    logic [P_W-1:0]    r_r;
    logic [P_W:0]      r_s;
    logic              r_sat0;
    logic              r_sat1;
    logic              r_dz;
    logic [FRAC_W-1:0] r_k0;

    logic [P_W:0]      w_s;
    logic              w_div_load;
    logic              w_div_step;
    logic              w_div_last;
    logic [P_W-1:0]    w_dividend;
    logic [P_W:0]      w_divisor;
    logic [c_Q_W-1:0]  w_quot;
    logic [FRAC_W-1:0] w_k_div;
    logic              w_sat;
    logic [FRAC_W-1:0] w_k_final;

    assign w_s        = {1'b0, r_p00} + {1'b0, r_r};
    assign w_dividend = (r_state == LOAD) ? r_p00 : r_p10;
    assign w_divisor  = (r_state == LOAD) ? w_s : r_s;
    assign w_sat      = (r_state == DIV0) ? r_sat0 : r_sat1;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

    kalman_seq_div #(
        .P_W   (P_W),
        .ITERS (c_Q_W)
    ) u_div (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_div_load),
        .step     (w_div_step),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_quot),
        .last     (w_div_last)
    );

    generate
        if (c_ROUND_EN != 0) begin : g_round
            // Guard bit adds half an LSB; a carry out means the gain hit 1.0.
            logic [FRAC_W:0] w_sum;
            assign w_sum   = {1'b0, w_quot[c_Q_W-1:1]} + {{FRAC_W{1'b0}}, w_quot[0]};
            assign w_k_div = w_sum[FRAC_W] ? c_KMAX : w_sum[FRAC_W-1:0];
        end else begin : g_trunc
            assign w_k_div = w_quot;
        end
    endgenerate

    always_comb begin
        w_k_final = w_k_div;
        if (r_dz) begin
            w_k_final = '0;
        end else if (w_sat) begin
            w_k_final = c_KMAX;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_next = LOAD;
            LOAD: begin
                w_div_load   = 1'b1;
                w_state_next = DIV0;
            end
            DIV0: begin
                w_div_step = 1'b1;
                // Reload for K1 on the same edge the K0 result is captured.
                if (w_div_last) begin
                    w_div_load   = 1'b1;
                    w_state_next = DIV1;
                end
            end
            DIV1: begin
                w_div_step = 1'b1;
                if (w_div_last) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_p00    <= '0;
            r_p10    <= '0;
            r_r      <= '0;
            r_s      <= '0;
            r_sat0   <= 1'b0;
            r_sat1   <= 1'b0;
            r_dz     <= 1'b0;
            r_k0     <= '0;
            K0_out   <= '0;
            K1_out   <= '0;
            div_zero <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_p00 <= P00_in;
                r_p10 <= P10_in;
                r_r   <= R_in;
            end
            if (r_state == LOAD) begin
                r_s    <= w_s;
                r_sat0 <= ({1'b0, r_p00} >= w_s);
                r_sat1 <= ({1'b0, r_p10} >= w_s);
                r_dz   <= (w_s == '0);
            end
            if ((r_state == DIV0) && w_div_last) begin
                r_k0 <= w_k_final;
            end
            if ((r_state == DIV1) && w_div_last) begin
                K0_out   <= r_k0;
                K1_out   <= w_k_final;
                div_zero <= r_dz;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kalman_gain_div.sv
`default_nettype none
// ============================================================================
// Module : tb_kalman_gain_div
// Brief  : Self-checking bench for kalman_gain_div against an arithmetic gain
//          model; honours KALMAN_GAIN_ROUND_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_kalman_gain_div;

    localparam int F = 13;
`ifdef KALMAN_GAIN_ROUND_EN
    localparam int LAT = 1 + 2 * (F + 1);
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 1 + 2 * F;
    localparam bit RND = 1'b0;
`endif
    localparam longint KMAX = 8191;

    logic        clk      = 1'b0;
    logic        n_rst    = 1'b0;
    logic        start    = 1'b0;
    logic [22:0] P00_in   = '0;
    logic [22:0] P10_in   = '0;
    logic [22:0] R_in     = '0;
    logic        busy;
    logic        done;
    logic [12:0] K0_out;
    logic [12:0] K1_out;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kalman_gain_div dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .P00_in   (P00_in),
        .P10_in   (P10_in),
        .R_in     (R_in),
        .busy     (busy),
        .done     (done),
        .K0_out   (K0_out),
        .K1_out   (K1_out),
        .div_zero (div_zero)
    );

    function automatic longint gain(input longint p, input longint s);
        longint q;
        if (RND) begin
            q = (p * (longint'(1) << (F + 1))) / s;
            q = (q + 1) / 2;
        end else begin
            q = (p * (longint'(1) << F)) / s;
        end
        return (q > KMAX) ? KMAX : q;
    endfunction

    // Packed {K0, K1, div_zero}
    function automatic logic [26:0] model(input longint p00, input longint p10, input longint r);
        longint s;
        s = p00 + r;
        if (s == 0) return {13'd0, 13'd0, 1'b1};
        return {13'(gain(p00, s)), 13'(gain(p10, s)), 1'b0};
    endfunction

    // Launches a run and returns edges from the start edge to the done cycle.
    task automatic run_op(input longint p00, input longint p10, input longint r,
                          input bit hold, output int lat, output bit busy_ok);
        P00_in = p00[22:0];
        P10_in = p10[22:0];
        R_in   = r[22:0];
        start  = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        lat     = -1;
        busy_ok = (busy === 1'b1);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, K0_out, K1_out, div_zero} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b K0=%0d K1=%0d dz=%b, required all zero",
                     busy, done, K0_out, K1_out, div_zero);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        longint vec [5][6];
        int lat;
        bit bok;
        logic [26:0] exp;
        vec[0] = '{1000, 500, 1000, 4096, 2048, 0};
        vec[1] = '{5000, 10000, 0, 8191, 8191, 0};
        vec[2] = '{0, 77, 0, 0, 0, 1};
        vec[3] = '{1000, 500, 1000, 4096, 2048, 0};
        vec[4] = '{1, 1, 2, RND ? 2731 : 2730, RND ? 2731 : 2730, 0};
        for (int i = 0; i < 5; i++) begin
            run_op(vec[i][0], vec[i][1], vec[i][2], 1'b0, lat, bok);
            exp = {13'(vec[i][3]), 13'(vec[i][4]), 1'(vec[i][5])};
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL dir[%0d] latency: got %0d, required %0d", i, lat, LAT);
            end
            n_cmp++;
            if (bok !== 1'b1) begin
                n_bad++;
                $display("FAIL dir[%0d] busy: got low during run, required high", i);
            end
            n_cmp++;
            if ({K0_out, K1_out, div_zero} !== exp) begin
                n_bad++;
                $display("FAIL dir[%0d] result: got K0=%0d K1=%0d dz=%b, required K0=%0d K1=%0d dz=%b",
                         i, K0_out, K1_out, div_zero, exp[26:14], exp[13:1], exp[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_held();
        int lat;
        bit bok;
        int ndone;
        run_op(3000, 1000, 1000, 1'b1, lat, bok);
        n_cmp++;
        if ({lat, K0_out, K1_out} !== {LAT, 13'd6144, 13'd2048}) begin
            n_bad++;
            $display("FAIL held result: got lat=%0d K0=%0d K1=%0d, required lat=%0d K0=6144 K1=2048",
                     lat, K0_out, K1_out, LAT);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_done_cycle_start: got busy=%b, required 0", busy);
        end
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL held_extra_done: got %0d, required 0", ndone);
        end
    endtask

    task automatic test_start_mid();
        int lat;
        int ndone;
        logic [26:0] exp;
        exp = model(2000, 1500, 6000);
        P00_in = 23'd2000;
        P10_in = 23'd1500;
        R_in   = 23'd6000;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({K0_out, K1_out} !== {13'd6144, 13'd2048}) begin
            n_bad++;
            $display("FAIL hold_outputs: got K0=%0d K1=%0d, required K0=6144 K1=2048", K0_out, K1_out);
        end
        P00_in = 23'd777;
        P10_in = 23'd3;
        R_in   = 23'd5;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 6; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if ({lat, K0_out, K1_out, div_zero} !== {LAT, exp}) begin
            n_bad++;
            $display("FAIL mid_start: got lat=%0d K0=%0d K1=%0d dz=%b, required lat=%0d K0=%0d K1=%0d dz=%b",
                     lat, K0_out, K1_out, div_zero, LAT, exp[26:14], exp[13:1], exp[0]);
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL mid_extra_done: got %0d, required 0", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        P00_in = 23'd1000;
        P10_in = 23'd500;
        R_in   = 23'd1000;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, K0_out, K1_out, div_zero} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b K0=%0d K1=%0d dz=%b, required all zero",
                     busy, done, K0_out, K1_out, div_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_op(1000, 500, 1000, 1'b0, lat, bok);
        n_cmp++;
        if ({lat, K0_out, K1_out, div_zero} !== {LAT, 13'd4096, 13'd2048, 1'b0}) begin
            n_bad++;
            $display("FAIL after_reset: got lat=%0d K0=%0d K1=%0d dz=%b, required lat=%0d K0=4096 K1=2048 dz=0",
                     lat, K0_out, K1_out, div_zero, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        longint p00, p10, r;
        int lat;
        bit bok;
        logic [26:0] exp;
        for (int i = 0; i < 24; i++) begin
            p00 = longint'($urandom_range(0, 32'h7FFFFF));
            p10 = longint'($urandom_range(0, 32'h7FFFFF));
            r   = longint'($urandom_range(0, 32'h7FFFFF));
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    p00 = longint'($urandom_range(0, 15));
                    p10 = longint'($urandom_range(0, 15));
                    r   = longint'($urandom_range(0, 15));
                end
                2: p10 = longint'($urandom_range(0, 32'(p00 + r)));
                default: r = 0;
            endcase
            if (p10 > 64'h7FFFFF) p10 = 64'h7FFFFF;
            exp = model(p00, p10, r);
            run_op(p00, p10, r, 1'b0, lat, bok);
            n_cmp++;
            if ({lat, bok, K0_out, K1_out, div_zero} !== {LAT, 1'b1, exp}) begin
                n_bad++;
                $display("FAIL rand[%0d] P00=%0d P10=%0d R=%0d: got lat=%0d busy_ok=%b K0=%0d K1=%0d dz=%b, required lat=%0d K0=%0d K1=%0d dz=%b",
                         i, p00, p10, r, lat, bok, K0_out, K1_out, div_zero,
                         LAT, exp[26:14], exp[13:1], exp[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_start_mid();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
